// File: rtl/fp_addsub_prep_if.sv
// Operand/result bundle for the FP add/sub preparation stage.
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side; valid must not depend on ready, and the payload is
// held stable while valid is high and ready is low.
interface fp_addsub_prep_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        mode_in;
    logic        out_valid;
    logic        out_ready;
    logic        mode;
    logic        comp;
    logic        magcheck;
    logic        zero;
    logic        A_sign;
    logic        B_sign;
    logic [7:0]  BigExp;
    logic [7:0]  SmallExp;
    logic [23:0] BigMan;
    logic [23:0] SmallMan;
    logic [1:0]  exc;

    // Upstream producer / downstream consumer side (the environment).
    modport master (
        output in_valid, A, B, mode_in, out_ready,
        input  in_ready, out_valid, mode, comp, magcheck, zero,
               A_sign, B_sign, BigExp, SmallExp, BigMan, SmallMan, exc
    );

    // The preparation block itself.
    modport slave (
        input  in_valid, A, B, mode_in, out_ready,
        output in_ready, out_valid, mode, comp, magcheck, zero,
               A_sign, B_sign, BigExp, SmallExp, BigMan, SmallMan, exc
    );
endinterface

// File: rtl/fp_addsub_prep.sv
// Two-stage front end for a single-precision adder: S1 captures the operands,
// S2 registers the magnitude compare, operand swap and exception class so the
// following shift/add stage always sees the larger magnitude as "Big".
module fp_addsub_prep (
    input  logic               clk,
    input  logic               rst,
    fp_addsub_prep_if.slave    bus
);

    // Stage 1 registers
    logic        r_s1_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_mode_s1;

    // Stage 2 registers (drive the outputs directly)
    logic        r_s2_valid;
    logic        r_mode;
    logic        r_comp;
    logic        r_magcheck;
    logic        r_zero;
    logic        r_a_sign;
    logic        r_b_sign;
    logic [7:0]  r_big_exp;
    logic [7:0]  r_small_exp;
    logic [23:0] r_big_man;
    logic [23:0] r_small_man;
    logic [1:0]  r_exc;

    // Combinational compare/swap results computed from S1
    logic        w_s2_load;
    logic        w_s1_load;
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [23:0] w_man_a;
    logic [23:0] w_man_b;
    logic        w_comp;
    logic        w_magcheck;
    logic        w_eff_sub;
    logic        w_zero;
    logic        w_a_big;
    logic        w_nan;
    logic        w_inf;
    logic [1:0]  w_exc;

    // Stage advance: S2 drains into the consumer, S1 drains into S2.
    assign w_s2_load   = ~r_s2_valid | bus.out_ready;
    assign w_s1_load   = ~r_s1_valid | w_s2_load;
    assign bus.in_ready = w_s1_load;

    // Field extraction, magnitude compare, swap selection and exception class.
    always_comb begin
        w_exp_a    = r_a[30:23];
        w_exp_b    = r_b[30:23];
        w_man_a    = {(w_exp_a != 8'h00), r_a[22:0]};
        w_man_b    = {(w_exp_b != 8'h00), r_b[22:0]};
        w_comp     = (w_exp_a > w_exp_b);
        w_magcheck = (w_exp_a == w_exp_b) & (w_man_a > w_man_b);
        // Magnitudes are subtracted when a subtract sees equal signs or an
        // add sees opposite signs (mode 1 = add).
        w_eff_sub  = r_a[31] ^ r_b[31] ^ ~r_mode_s1;
        w_zero     = (w_exp_a == w_exp_b) & (w_man_a == w_man_b) & w_eff_sub;
        w_a_big    = w_comp | w_magcheck;
        w_nan      = ((w_exp_a == 8'hFF) & (r_a[22:0] != 23'd0)) |
                     ((w_exp_b == 8'hFF) & (r_b[22:0] != 23'd0));
        w_inf      = ((w_exp_a == 8'hFF) & (r_a[22:0] == 23'd0)) |
                     ((w_exp_b == 8'hFF) & (r_b[22:0] == 23'd0));
        w_exc      = 2'b00;
        if (w_nan) begin
            w_exc = 2'b01;
        end else if (w_inf) begin
            w_exc = 2'b10;
        end
    end

    // S1: capture the operand pair whenever the stage is free to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_mode_s1  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_a       <= bus.A;
                r_b       <= bus.B;
                r_mode_s1 <= bus.mode_in;
            end
        end
    end

    // S2: register compare/swap results; payload only changes on a real pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_mode      <= 1'b0;
            r_comp      <= 1'b0;
            r_magcheck  <= 1'b0;
            r_zero      <= 1'b0;
            r_a_sign    <= 1'b0;
            r_b_sign    <= 1'b0;
            r_big_exp   <= 8'd0;
            r_small_exp <= 8'd0;
            r_big_man   <= 24'd0;
            r_small_man <= 24'd0;
            r_exc       <= 2'b00;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mode      <= r_mode_s1;
                r_comp      <= w_comp;
                r_magcheck  <= w_magcheck;
                r_zero      <= w_zero;
                r_a_sign    <= r_a[31];
                r_b_sign    <= r_b[31];
                r_big_exp   <= w_a_big ? w_exp_a : w_exp_b;
                r_small_exp <= w_a_big ? w_exp_b : w_exp_a;
                r_big_man   <= w_a_big ? w_man_a : w_man_b;
                r_small_man <= w_a_big ? w_man_b : w_man_a;
                r_exc       <= w_exc;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.mode      = r_mode;
    assign bus.comp      = r_comp;
    assign bus.magcheck  = r_magcheck;
    assign bus.zero      = r_zero;
    assign bus.A_sign    = r_a_sign;
    assign bus.B_sign    = r_b_sign;
    assign bus.BigExp    = r_big_exp;
    assign bus.SmallExp  = r_small_exp;
    assign bus.BigMan    = r_big_man;
    assign bus.SmallMan  = r_small_man;
    assign bus.exc       = r_exc;

endmodule

// File: tb/tb_fp_addsub_prep.sv
// Bench for fp_addsub_prep: directed vectors, back-pressure and reset cases,
// then randomized traffic against a magnitude-level reference model.
module tb_fp_addsub_prep;

    logic clk;
    logic rst;
    fp_addsub_prep_if bus ();

    fp_addsub_prep dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [71:0] exp_q[$];
    logic        rand_rdy = 1'b0;
    logic [71:0] act;

    assign act = {bus.mode, bus.comp, bus.magcheck, bus.zero, bus.A_sign, bus.B_sign,
                  bus.BigExp, bus.SmallExp, bus.BigMan, bus.SmallMan, bus.exc};

    function automatic logic [71:0] pack(input logic m, input logic c, input logic mg,
                                         input logic z, input logic as, input logic bs,
                                         input logic [7:0] be, input logic [7:0] se,
                                         input logic [23:0] bm, input logic [23:0] sm,
                                         input logic [1:0] e);
        return {m, c, mg, z, as, bs, be, se, bm, sm, e};
    endfunction

    // Reference: order operands by IEEE magnitude (bits 30:0 as an integer).
    function automatic logic [71:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic m);
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic        a_big, eff_sub, nan, inf;
        logic [1:0]  e;
        ea = a[30:23];
        eb = b[30:23];
        ma = {(ea != 0), a[22:0]};
        mb = {(eb != 0), b[22:0]};
        a_big = a[30:0] > b[30:0];
        eff_sub = m ? (a[31] != b[31]) : (a[31] == b[31]);
        nan = (ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0);
        inf = (ea == 8'hFF) || (eb == 8'hFF);
        e = nan ? 2'b01 : (inf ? 2'b10 : 2'b00);
        return pack(m, ea > eb, (ea == eb) && (a[22:0] > b[22:0]),
                    (a[30:0] == b[30:0]) && eff_sub, a[31], b[31],
                    a_big ? ea : eb, a_big ? eb : ea,
                    a_big ? ma : mb, a_big ? mb : ma, e);
    endfunction

    task automatic check_bit(input string name, input logic actual, input logic expv);
        checks++;
        if (actual !== expv) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, actual, expv);
        end
    endtask

    // Driver: present one pair, push its expectation when accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [71:0] e);
        int n;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.mode_in = m;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 100) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: in_ready stuck low for A=%h", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Random back-pressure generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard: compare on each output transfer, and check that a
    // stalled bundle does not change.
    initial begin
        logic        hold_valid;
        logic [71:0] held;
        logic [71:0] e;
        hold_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    checks++;
                    if (act !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got %h expected %h", act, held);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL bundle: got %h expected %h", act, e);
                        end
                    end
                end
                hold_valid = bus.out_valid && !bus.out_ready;
                held = act;
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] a, b;
        logic        m;
        int          acc;
        int          sel;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.mode_in = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        checks++;
        if (act !== 72'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", act);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_bit("ready_after_reset", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Directed vectors
        send(32'h40400000, 32'h3F800000, 1'b1,
             pack(1, 1, 0, 0, 0, 0, 8'h80, 8'h7F, 24'hC00000, 24'h800000, 2'b00));
        send(32'h3F800000, 32'h3F800000, 1'b0,
             pack(0, 0, 0, 1, 0, 0, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 2'b00));
        send(32'h3F800000, 32'h3F800000, 1'b1,
             pack(1, 0, 0, 0, 0, 0, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 2'b00));
        send(32'h3F800000, 32'hBFC00000, 1'b1,
             pack(1, 0, 0, 0, 0, 1, 8'h7F, 8'h7F, 24'hC00000, 24'h800000, 2'b00));
        send(32'h7FC00000, 32'h7F800000, 1'b1,
             pack(1, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 24'hC00000, 24'h800000, 2'b01));
        send(32'h00000001, 32'h00000000, 1'b1,
             pack(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 24'h000001, 24'h000000, 2'b00));
        drain();

        // Back-pressure: two pairs fit, then in_ready must fall.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        a = $urandom(); b = $urandom(); m = 1'($urandom_range(0, 1));
        bus.A = a; bus.B = b; bus.mode_in = m;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) check_bit("stall_in_ready", bus.in_ready, 1'b0);
            if (bus.in_ready) begin
                exp_q.push_back(model(a, b, m));
                acc++;
                @(posedge clk);
                #1;
                a = $urandom(); b = $urandom(); m = 1'($urandom_range(0, 1));
                bus.A = a; bus.B = b; bus.mode_in = m;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL stall_accept_count: got %0d expected 2", acc);
        end
        drain();

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        send($urandom(), $urandom(), 1'b1, 72'd0);
        send($urandom(), $urandom(), 1'b0, 72'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_bit("async_reset_out_valid", bus.out_valid, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_bit("ready_after_midreset", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_bit("no_stale_output", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            sel = $urandom_range(0, 4);
            case (sel)
                0: b = $urandom();
                1: b = {1'($urandom_range(0, 1)), a[30:23], 23'($urandom())};
                2: b = {1'($urandom_range(0, 1)), a[30:0]};
                3: b = {1'($urandom_range(0, 1)), 8'hFF,
                        ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom())};
                default: b = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom())};
            endcase
            if ($urandom_range(0, 1) != 0) begin
                a = b;
                b = $urandom();
            end
            m = 1'($urandom_range(0, 1));
            send(a, b, m, model(a, b, m));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
